// File: rtl/buzzer_note_sequencer_if.sv
// Register-bank <-> note sequencer bundle: note pushes, playback control,
// timing configuration, buzzer drive and status.
interface buzzer_note_sequencer_if #(
   parameter int FIFO_DEPTH = 16,
   parameter int BEAT_W     = 24
);
   logic                          note_wr;
   logic [7:0]                    note_code;
   logic [7:0]                    note_beats;
   logic                          start;
   logic                          stop;
   logic                          flush;
   logic [BEAT_W-1:0]             beat_len;
   logic [BEAT_W-1:0]             gap_len;
   logic [7:0]                    tune_data;
   logic                          tune_pwm_en;
   logic                          busy;
   logic                          beat_finish;
   logic                          song_done;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic                          fifo_full;
   logic                          overflow;

   modport master (
      output note_wr, note_code, note_beats, start, stop, flush, beat_len, gap_len,
      input  tune_data, tune_pwm_en, busy, beat_finish, song_done, fifo_level,
             fifo_full, overflow
   );

   modport slave (
      input  note_wr, note_code, note_beats, start, stop, flush, beat_len, gap_len,
      output tune_data, tune_pwm_en, busy, beat_finish, song_done, fifo_level,
             fifo_full, overflow
   );
endinterface

// File: rtl/buzzer_note_sequencer.sv
// Autonomous buzzer note sequencer: a FIFO of (code, beats) pairs played back
// for an exact number of beats each, with a programmable silent gap between notes.
module buzzer_note_sequencer #(
   parameter int FIFO_DEPTH = 16,
   parameter int BEAT_W     = 24
) (
   input logic                    HCLK,
   input logic                    HRESET,
   buzzer_note_sequencer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

   function automatic logic [BEAT_W-1:0] len_min1(input logic [BEAT_W-1:0] v);
      return (v == '0) ? BEAT_W'(1) : v;
   endfunction

   function automatic logic [7:0] beats_min1(input logic [7:0] v);
      return (v == 8'd0) ? 8'd1 : v;
   endfunction

   logic [15:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              overflow_q, overflow_d;

   state_t            state_q;
   logic [7:0]        tune_data_q;
   logic              pwm_en_q;
   logic              song_done_q;
   logic [7:0]        beats_left_q;
   logic [BEAT_W-1:0] beat_len_q;
   logic [BEAT_W-1:0] gap_len_q;
   logic [BEAT_W-1:0] beat_cnt_q;
   logic [BEAT_W-1:0] gap_cnt_q;

   logic              full;
   logic              push_ok;
   logic              pop;
   logic              fifo_avail;
   logic              beat_last;
   logic              gap_last;
   logic [15:0]       head;

   assign full       = (level_q == LW'(FIFO_DEPTH));
   assign push_ok    = bus.note_wr && !full && !bus.flush;
   // An aborted LOAD leaves its entry in the FIFO for the next start.
   assign pop        = (state_q == S_LOAD) && (level_q != '0) && !bus.flush && !bus.stop;
   assign fifo_avail = (level_q != '0) && !bus.flush;
   assign head       = mem_q[rd_ptr_q];
   assign beat_last  = (beat_cnt_q == beat_len_q - BEAT_W'(1));
   assign gap_last   = (gap_cnt_q == gap_len_q - BEAT_W'(1));

   always_ff @(posedge HCLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {bus.note_code, bus.note_beats};
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (bus.flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push_ok) - LW'(pop);
         if (bus.note_wr && full) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q      <= S_IDLE;
         tune_data_q  <= 8'd0;
         pwm_en_q     <= 1'b0;
         song_done_q  <= 1'b0;
         beats_left_q <= 8'd0;
         beat_len_q   <= '0;
         gap_len_q    <= '0;
         beat_cnt_q   <= '0;
         gap_cnt_q    <= '0;
      end else begin
         song_done_q <= 1'b0;
         if (bus.stop) begin
            state_q  <= S_IDLE;
            pwm_en_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.start && fifo_avail) state_q <= S_LOAD;
               end
               S_LOAD: begin
                  tune_data_q  <= head[15:8];
                  pwm_en_q     <= (head[15:8] != 8'd0);
                  beats_left_q <= beats_min1(head[7:0]);
                  beat_len_q   <= len_min1(bus.beat_len);
                  gap_len_q    <= bus.gap_len;
                  beat_cnt_q   <= '0;
                  state_q      <= S_PLAY;
               end
               S_PLAY: begin
                  if (beat_last) begin
                     beat_cnt_q <= '0;
                     if (beats_left_q == 8'd1) begin
                        pwm_en_q <= 1'b0;
                        if (gap_len_q != '0) begin
                           gap_cnt_q <= '0;
                           state_q   <= S_GAP;
                        end else if (fifo_avail) begin
                           state_q <= S_LOAD;
                        end else begin
                           state_q     <= S_IDLE;
                           song_done_q <= 1'b1;
                        end
                     end else begin
                        beats_left_q <= beats_left_q - 8'd1;
                     end
                  end else begin
                     beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                  end
               end
               S_GAP: begin
                  if (gap_last) begin
                     if (fifo_avail) begin
                        state_q <= S_LOAD;
                     end else begin
                        state_q     <= S_IDLE;
                        song_done_q <= 1'b1;
                     end
                  end else begin
                     gap_cnt_q <= gap_cnt_q + BEAT_W'(1);
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.tune_data   = tune_data_q;
   assign bus.tune_pwm_en = pwm_en_q;
   assign bus.song_done   = song_done_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.beat_finish = (state_q == S_PLAY) && beat_last;
   assign bus.fifo_level  = level_q;
   assign bus.fifo_full   = full;
   assign bus.overflow    = overflow_q;
endmodule
